mem_arbiter_rr: RTL

Round-robin arbiter and sequencer that shares one memory port among `N_ACCESSORS` requesters (core, cache, debug, ...). It replaces fixed-priority sharing in front of `mem`. It latches one accessor's request and drives a single valid/valid transaction to the memory. It returns load data and a done/error handshake to the granted accessor. A bounded wait counter aborts transactions the memory never acknowledges.

---
 rtl/mem_arbiter_rr.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter/sequencer sharing one memory port among N accessors.
// One latched request at a time; done/err held until the owner drops its request.
module mem_arbiter_rr #(
  parameter int BITSIZE          = 32,
  parameter int N_WORDS_PER_ADDR = 4,
  parameter int N_ACCESSORS      = 2,
  parameter int TIMEOUT_CYCLES   = 64,
  localparam int LW              = N_WORDS_PER_ADDR * BITSIZE
) (
  input  logic                      clk,
  input  logic                      resetn_i,
  input  logic [32*N_ACCESSORS-1:0] acc_address_i,
  input  logic [N_ACCESSORS-1:0]    acc_store_i,
  input  logic [N_ACCESSORS-1:0]    acc_load_i,
  input  logic [LW*N_ACCESSORS-1:0] acc_data_i,
  output logic [LW*N_ACCESSORS-1:0] acc_data_o,
  output logic [N_ACCESSORS-1:0]    acc_done_o,
  output logic [N_ACCESSORS-1:0]    acc_err_o,
  output logic [N_ACCESSORS-1:0]    grant_o,
  output logic [31:0]               mem_addr_o,
  output logic [LW-1:0]             mem_data_o,
  output logic                      mem_store_o,
  output logic                      mem_valid_o,
  input  logic [LW-1:0]             mem_data_i,
  input  logic                      mem_valid_i
);

  localparam int IW = (N_ACCESSORS > 1) ? $clog2(N_ACCESSORS) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t                 state_reg, state_next;
  logic [IW-1:0]          rr_ptr_reg;
  logic [IW-1:0]          gidx_reg;
  logic [IW-1:0]          pick_idx;
  logic                   pick_valid;
  logic [CW-1:0]          cnt_reg;
  logic                   err_reg;
  logic                   timeout_hit;
  logic [N_ACCESSORS-1:0] req_vec;
  logic [31:0]            addr_arr  [N_ACCESSORS];
  logic [LW-1:0]          wdata_arr [N_ACCESSORS];

  assign req_vec     = acc_load_i | acc_store_i;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_reg == CW'(TIMEOUT_CYCLES));

  generate
    for (genvar gi = 0; gi < N_ACCESSORS; gi++) begin : g_acc
      logic [LW-1:0] rdata_reg;

      assign addr_arr[gi]               = acc_address_i[32*gi +: 32];
      assign wdata_arr[gi]              = acc_data_i[LW*gi +: LW];
      assign acc_data_o[LW*gi +: LW]    = rdata_reg;

      // Only a successful load owned by this slice updates it.
      always_ff @(posedge clk or negedge resetn_i) begin
        if (!resetn_i) begin
          rdata_reg <= '0;
        end else if (state_reg == S_REQ && mem_valid_i && !mem_store_o &&
                     gidx_reg == IW'(gi)) begin
          rdata_reg <= mem_data_i;
        end
      end
    end
  endgenerate

  // Walk downward so the last hit is the first requester at/after rr_ptr.
  always_comb begin
    int idx;
    pick_valid = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    for (int i = N_ACCESSORS - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr_reg) + i) % N_ACCESSORS;
      if (req_vec[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn_i) begin
    if (!resetn_i) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (pick_valid) state_next = S_REQ;
      S_REQ:   if (mem_valid_i || timeout_hit) state_next = S_DONE;
      S_DONE:  if (!req_vec[gidx_reg]) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_valid_o = (state_reg == S_REQ);
    acc_done_o  = '0;
    if (state_reg == S_DONE) acc_done_o = grant_o;
    acc_err_o   = err_reg ? acc_done_o : '0;
  end

  always_ff @(posedge clk or negedge resetn_i) begin
    if (!resetn_i) begin
      rr_ptr_reg  <= '0;
      gidx_reg    <= '0;
      cnt_reg     <= '0;
      err_reg     <= 1'b0;
      grant_o     <= '0;
      mem_addr_o  <= '0;
      mem_data_o  <= '0;
      mem_store_o <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (pick_valid) begin
            mem_addr_o  <= addr_arr[pick_idx];
            mem_data_o  <= wdata_arr[pick_idx];
            mem_store_o <= acc_store_i[pick_idx];
            grant_o     <= {{(N_ACCESSORS-1){1'b0}}, 1'b1} << pick_idx;
            gidx_reg    <= pick_idx;
            cnt_reg     <= '0;
          end
        end
        S_REQ: begin
          if (!mem_valid_i) begin
            if (timeout_hit) begin
              err_reg <= 1'b1;
            end else if (cnt_reg != {CW{1'b1}}) begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        S_DONE: begin
          if (!req_vec[gidx_reg]) begin
            rr_ptr_reg <= (gidx_reg == IW'(N_ACCESSORS - 1)) ? '0 : gidx_reg + 1'b1;
            grant_o    <= '0;
            err_reg    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
